// File: rtl/key_press_decoder_pkg.sv
// Shared definitions for the push-button front end.
// Holds the per-key state encoding, the default channel count and small
// helpers that turn millisecond settings into clock-cycle counts.
package key_press_decoder_pkg;

    localparam int unsigned DEF_N_KEYS = 4;

    // Per-key classification state. The unused code 2'd3 is steered back
    // to ST_IDLE by the channel FSM.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } key_state_t;

    // Number of clock cycles in a given number of milliseconds.
    function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                                 input int unsigned ms);
        return (clk_hz / 1000) * ms;
    endfunction

    // Largest of three cycle counts, used to size the shared counters.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_press_decoder_if.sv
// Bundle of raw key inputs and decoded key events.
// Ports (signals):
//   KEY          raw buttons, 0 = pressed
//   key_level    debounced state, 1 = pressed
//   short_pulse  one-cycle event on release of a short press
//   long_pulse   one-cycle event when a hold reaches the long threshold
//   repeat_pulse one-cycle event at every repeat period after long_pulse
// master: drives KEY and consumes events; slave: the decoder itself.
interface key_press_decoder_if
    import key_press_decoder_pkg::*;
#(
    parameter int unsigned N_KEYS = DEF_N_KEYS
);

    logic [N_KEYS-1:0] KEY;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] short_pulse;
    logic [N_KEYS-1:0] long_pulse;
    logic [N_KEYS-1:0] repeat_pulse;

    modport master (
        output KEY,
        input  key_level,
        input  short_pulse,
        input  long_pulse,
        input  repeat_pulse
    );

    modport slave (
        input  KEY,
        output key_level,
        output short_pulse,
        output long_pulse,
        output repeat_pulse
    );

endinterface

// File: rtl/key_press_decoder_key_channel.sv
// One push-button channel: two-flop synchroniser, debouncer and the
// short/long/repeat press classifier.
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   key_n        raw button, 0 = pressed, asynchronous to clk
//   key_level    debounced level, 1 = pressed
//   short_pulse  one-cycle pulse on release before the long threshold
//   long_pulse   one-cycle pulse when the hold reaches the long threshold
//   repeat_pulse one-cycle pulse every repeat period while still held
module key_channel
    import key_press_decoder_pkg::*;
#(
    parameter int unsigned DB_CYC   = 4,
    parameter int unsigned LONG_CYC = 20,
    parameter int unsigned REP_CYC  = 5,
    parameter int          CNT_W    = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic key_level,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = (REP_CYC == 0) ? '0 : CNT_W'(REP_CYC - 1);
    localparam bit               REPEAT_EN = (REP_CYC != 0);

    logic             sync_a;
    logic             sync_b;
    logic             stable;
    logic [CNT_W-1:0] db_cnt;
    logic [CNT_W-1:0] hold_cnt;
    key_state_t       state;

    logic key_s;
    logic db_flip;
    logic rise;
    logic fall;

    // The synchroniser idles at 1 (released), so inverting it gives an
    // active-high pressed signal. db_flip marks the cycle in which the
    // debounced level is about to change; the FSM reacts to that same
    // cycle so its events line up with key_level edges.
    assign key_s   = ~sync_b;
    assign db_flip = (key_s != stable) && (db_cnt == DB_LAST);
    assign rise    = db_flip && !stable;
    assign fall    = db_flip && stable;

    assign key_level = stable;

    // Synchronise the raw button and debounce it: a new level has to be
    // seen continuously for DB_CYC cycles before it is accepted, and any
    // cycle agreeing with the accepted level restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
            stable <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync_a <= key_n;
            sync_b <= sync_a;
            if (key_s != stable) begin
                if (db_cnt == DB_LAST) begin
                    stable <= ~stable;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    // Press classifier with registered one-cycle event outputs. A release
    // is checked before any hold threshold, so a release landing on the
    // threshold cycle yields only the release action. When repeat is
    // disabled the hold counter parks in ST_LONG instead of running on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            hold_cnt     <= '0;
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state    <= ST_HELD;
                        hold_cnt <= '0;
                    end
                end
                ST_HELD: begin
                    if (fall) begin
                        short_pulse <= 1'b1;
                        state       <= ST_IDLE;
                        hold_cnt    <= '0;
                    end else if (hold_cnt == LONG_LAST) begin
                        long_pulse <= 1'b1;
                        state      <= ST_LONG;
                        hold_cnt   <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_LONG: begin
                    if (fall) begin
                        state    <= ST_IDLE;
                        hold_cnt <= '0;
                    end else if (REPEAT_EN) begin
                        if (hold_cnt == REP_LAST) begin
                            repeat_pulse <= 1'b1;
                            hold_cnt     <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_press_decoder.sv
// Front end for the DE2 push-buttons: debounces each active-low key and
// classifies presses into short, long and auto-repeat event pulses for
// key_control downstream.
// Ports:
//   CLOCK_50  system clock, rising edge
//   rst       asynchronous active-high reset
//   keys      slave side of key_press_decoder_if (KEY in, events out)
module key_press_decoder
    import key_press_decoder_pkg::*;
#(
    parameter int unsigned N_KEYS      = DEF_N_KEYS,
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000,
    parameter int unsigned REPEAT_MS   = 200
) (
    input  logic               CLOCK_50,
    input  logic               rst,
    key_press_decoder_if.slave keys
);

    localparam int unsigned DB_CYC   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int unsigned LONG_CYC = ms_to_cycles(CLK_HZ, LONG_MS);
    localparam int unsigned REP_CYC  = ms_to_cycles(CLK_HZ, REPEAT_MS);
    localparam int unsigned MAX_CYC  = max3(DB_CYC, LONG_CYC, REP_CYC);
    localparam int          CNT_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // A zero debounce window or a long threshold inside the debounce window
    // cannot be classified sensibly, so such settings stop elaboration.
    if (DB_CYC < 1 || LONG_CYC <= DB_CYC) begin : g_bad_cfg
        $error("key_press_decoder: requires DB_CYC >= 1 and LONG_CYC > DB_CYC");
    end

    logic [N_KEYS-1:0] level_vec;
    logic [N_KEYS-1:0] short_vec;
    logic [N_KEYS-1:0] long_vec;
    logic [N_KEYS-1:0] rep_vec;

    // Each key is handled by its own independent channel.
    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_channel #(
            .DB_CYC   (DB_CYC),
            .LONG_CYC (LONG_CYC),
            .REP_CYC  (REP_CYC),
            .CNT_W    (CNT_W)
        ) u_chan (
            .clk          (CLOCK_50),
            .rst          (rst),
            .key_n        (keys.KEY[i]),
            .key_level    (level_vec[i]),
            .short_pulse  (short_vec[i]),
            .long_pulse   (long_vec[i]),
            .repeat_pulse (rep_vec[i])
        );
    end

    assign keys.key_level    = level_vec;
    assign keys.short_pulse  = short_vec;
    assign keys.long_pulse   = long_vec;
    assign keys.repeat_pulse = rep_vec;

endmodule

// File: tb/tb_key_press_decoder.sv
// Directed bench for key_press_decoder with 1 kHz clock settings so that
// one millisecond equals one cycle: debounce 4, long 20, repeat 5.
module tb_key_press_decoder;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    int short_cnt [4] = '{default: 0};
    int long_cnt  [4] = '{default: 0};
    int rep_cnt   [4] = '{default: 0};
    int snap_short [4];
    int snap_long  [4];
    int snap_rep   [4];

    key_press_decoder_if #(.N_KEYS(4)) bus ();

    key_press_decoder #(
        .N_KEYS      (4),
        .CLK_HZ      (1000),
        .DEBOUNCE_MS (4),
        .LONG_MS     (20),
        .REPEAT_MS   (5)
    ) dut (
        .CLOCK_50 (clk),
        .rst      (rst),
        .keys     (bus)
    );

    always #5 clk = ~clk;

    // Count cycles each event output is high, sampled mid-cycle, so a pulse
    // stretched past one cycle shows up as an extra count.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bus.short_pulse[i] === 1'b1)  short_cnt[i] <= short_cnt[i] + 1;
            if (bus.long_pulse[i] === 1'b1)   long_cnt[i]  <= long_cnt[i] + 1;
            if (bus.repeat_pulse[i] === 1'b1) rep_cnt[i]   <= rep_cnt[i] + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] key_n);
        bus.KEY = key_n;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic takeSnapshot();
        for (int i = 0; i < 4; i++) begin
            snap_short[i] = short_cnt[i];
            snap_long[i]  = long_cnt[i];
            snap_rep[i]   = rep_cnt[i];
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(4'b1111);

        // Reset state
        repeat (3) tick();
        checkOutput("rst_level", 32'(bus.key_level), 32'h0);
        checkOutput("rst_short", 32'(bus.short_pulse), 32'h0);
        checkOutput("rst_long", 32'(bus.long_pulse), 32'h0);
        checkOutput("rst_rep", 32'(bus.repeat_pulse), 32'h0);
        rst = 1'b0;
        repeat (8) tick();
        checkOutput("idle_level", 32'(bus.key_level), 32'h0);

        // KEY[0] glitch of 3 cycles is shorter than the debounce window
        $display("[TB] glitch on KEY[0]");
        takeSnapshot();
        applyStimulus(4'b1110);
        for (int t = 1; t <= 12; t++) begin
            tick();
            checkOutput($sformatf("glitch_level c%0d", t), 32'(bus.key_level), 32'h0);
            if (t == 3) applyStimulus(4'b1111);
        end
        checkOutput("glitch_short_cnt", 32'(short_cnt[0] - snap_short[0]), 32'h0);

        // KEY[1] short press of 10 cycles
        $display("[TB] short press on KEY[1]");
        takeSnapshot();
        applyStimulus(4'b1101);
        for (int t = 1; t <= 22; t++) begin
            tick();
            checkOutput($sformatf("short_level c%0d", t), 32'(bus.key_level),
                        (t >= 6 && t < 16) ? 32'h2 : 32'h0);
            checkOutput($sformatf("short_pulse c%0d", t), 32'(bus.short_pulse),
                        (t == 16) ? 32'h2 : 32'h0);
            if (t == 10) applyStimulus(4'b1111);
        end
        checkOutput("short_cnt", 32'(short_cnt[1] - snap_short[1]), 32'h1);
        checkOutput("short_long_cnt", 32'(long_cnt[1] - snap_long[1]), 32'h0);
        checkOutput("short_rep_cnt", 32'(rep_cnt[1] - snap_rep[1]), 32'h0);

        // KEY[2] held 40 cycles: long at 26, repeats at 31/36/41, and the
        // release at 46 coincides with the next repeat threshold
        $display("[TB] long hold on KEY[2]");
        takeSnapshot();
        applyStimulus(4'b1011);
        for (int t = 1; t <= 50; t++) begin
            tick();
            checkOutput($sformatf("long_level c%0d", t), 32'(bus.key_level),
                        (t >= 6 && t < 46) ? 32'h4 : 32'h0);
            checkOutput($sformatf("long_pulse c%0d", t), 32'(bus.long_pulse),
                        (t == 26) ? 32'h4 : 32'h0);
            checkOutput($sformatf("long_rep c%0d", t), 32'(bus.repeat_pulse),
                        (t == 31 || t == 36 || t == 41) ? 32'h4 : 32'h0);
            checkOutput($sformatf("long_short c%0d", t), 32'(bus.short_pulse), 32'h0);
            if (t == 40) applyStimulus(4'b1111);
        end
        checkOutput("long_cnt", 32'(long_cnt[2] - snap_long[2]), 32'h1);
        checkOutput("long_rep_cnt", 32'(rep_cnt[2] - snap_rep[2]), 32'h3);
        checkOutput("long_short_cnt", 32'(short_cnt[2] - snap_short[2]), 32'h0);
        repeat (4) tick();

        // All four keys pressed together for 10 cycles
        $display("[TB] simultaneous press on all keys");
        takeSnapshot();
        applyStimulus(4'b0000);
        for (int t = 1; t <= 22; t++) begin
            tick();
            checkOutput($sformatf("all_level c%0d", t), 32'(bus.key_level),
                        (t >= 6 && t < 16) ? 32'hF : 32'h0);
            checkOutput($sformatf("all_short c%0d", t), 32'(bus.short_pulse),
                        (t == 16) ? 32'hF : 32'h0);
            if (t == 10) applyStimulus(4'b1111);
        end
        checkOutput("all_short_cnt3", 32'(short_cnt[3] - snap_short[3]), 32'h1);
        checkOutput("all_long_cnt0", 32'(long_cnt[0] - snap_long[0]), 32'h0);

        // KEY[0] bounces for 8 cycles, settles low at cycle 8, released at 20
        $display("[TB] bouncing KEY[0]");
        takeSnapshot();
        applyStimulus(4'b1110);
        for (int t = 1; t <= 30; t++) begin
            tick();
            checkOutput($sformatf("bounce_level c%0d", t), 32'(bus.key_level),
                        (t >= 14 && t < 26) ? 32'h1 : 32'h0);
            checkOutput($sformatf("bounce_short c%0d", t), 32'(bus.short_pulse),
                        (t == 26) ? 32'h1 : 32'h0);
            if (t < 8)        applyStimulus({3'b111, 1'(t % 2)});
            else if (t == 8)  applyStimulus(4'b1110);
            else if (t == 20) applyStimulus(4'b1111);
        end
        checkOutput("bounce_short_cnt", 32'(short_cnt[0] - snap_short[0]), 32'h1);

        // Reset pulsed while KEY[1] is in HELD; the key stays down through it
        $display("[TB] reset during KEY[1] hold");
        takeSnapshot();
        applyStimulus(4'b1101);
        repeat (10) tick();
        checkOutput("mid_level_pre", 32'(bus.key_level), 32'h2);
        rst = 1'b1;
        #1;
        checkOutput("mid_level_async", 32'(bus.key_level), 32'h0);
        checkOutput("mid_short_async", 32'(bus.short_pulse), 32'h0);
        tick();
        tick();
        checkOutput("mid_level_rst", 32'(bus.key_level), 32'h0);
        checkOutput("mid_long_rst", 32'(bus.long_pulse), 32'h0);
        rst = 1'b0;
        for (int t = 13; t <= 40; t++) begin
            tick();
            checkOutput($sformatf("mid_level c%0d", t), 32'(bus.key_level),
                        (t >= 18 && t < 31) ? 32'h2 : 32'h0);
            checkOutput($sformatf("mid_short c%0d", t), 32'(bus.short_pulse),
                        (t == 31) ? 32'h2 : 32'h0);
            if (t == 25) applyStimulus(4'b1111);
        end
        checkOutput("mid_short_cnt", 32'(short_cnt[1] - snap_short[1]), 32'h1);
        checkOutput("mid_long_cnt", 32'(long_cnt[1] - snap_long[1]), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
